// File: rtl/shift_arbiter_if.sv
// Bundles the two requester ports, the shifter tap and the response slot.
// The arbiter takes the slave view; requesters, shifter and consumer take the master view.
interface shift_arbiter_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         req0_valid;
    logic [N-1:0] req0_in;
    logic [C-1:0] req0_cnt;
    logic         req0_op;
    logic         req0_ready;

    logic         req1_valid;
    logic [N-1:0] req1_in;
    logic [C-1:0] req1_cnt;
    logic         req1_op;
    logic         req1_ready;

    logic [N-1:0] sh_in;
    logic [C-1:0] sh_cnt;
    logic         sh_op;
    logic [N-1:0] sh_out;

    logic         rsp_valid;
    logic [N-1:0] rsp_data;
    logic         rsp_id;
    logic         rsp_ready;

    logic         busy;

    modport slave (
        input  req0_valid, req0_in, req0_cnt, req0_op,
        output req0_ready,
        input  req1_valid, req1_in, req1_cnt, req1_op,
        output req1_ready,
        output sh_in, sh_cnt, sh_op,
        input  sh_out,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_in, req0_cnt, req0_op,
        input  req0_ready,
        output req1_valid, req1_in, req1_cnt, req1_op,
        input  req1_ready,
        input  sh_in, sh_cnt, sh_op,
        output sh_out,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter between two requesters; result lands in a
// one-entry slot one cycle after acceptance, and a full unconsumed slot stalls both requesters.
module shift_arbiter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_arbiter_if.slave    bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_id_q, rsp_id_d;
    logic         last_grant_q, last_grant_d;

    logic slot_free;
    logic gnt0, gnt1, gnt_any;

    // A tie goes to whoever did not win last; readies are held low while in reset.
    always_comb begin
        slot_free = (state_q == EMPTY) || bus.rsp_ready;
        gnt0      = !rst && slot_free && bus.req0_valid && (!bus.req1_valid || last_grant_q);
        gnt1      = !rst && slot_free && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        gnt_any   = gnt0 || gnt1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (gnt_any) begin
            state_d      = FULL;
            rsp_data_d   = bus.sh_out;
            rsp_id_d     = gnt1;
            last_grant_d = gnt1;
        end else if (state_q == FULL && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        bus.sh_in      = '0;
        bus.sh_cnt     = '0;
        bus.sh_op      = 1'b0;
        if (gnt1) begin
            bus.sh_in  = bus.req1_in;
            bus.sh_cnt = bus.req1_cnt;
            bus.sh_op  = bus.req1_op;
        end else if (gnt0) begin
            bus.sh_in  = bus.req0_in;
            bus.sh_cnt = bus.req0_cnt;
            bus.sh_op  = bus.req0_op;
        end
        bus.rsp_valid = (state_q == FULL);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_id    = rsp_id_q;
        bus.busy      = (state_q == FULL) || bus.req0_valid || bus.req1_valid;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: behavioural shifter on the tap, scoreboard of expected results.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [16:0] sb[$];

    shift_arbiter_if #(.N(16), .C(4)) bus ();

    shift_arbiter #(.N(16), .C(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shifter built one bit-step at a time.
    always_comb begin
        logic [15:0] v;
        v = bus.sh_in;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(bus.sh_cnt))
                v = {(bus.sh_op ? 1'b0 : v[0]), v[15:1]};
        end
        bus.sh_out = v;
    end

    function automatic logic [15:0] exp_shift(input logic [15:0] d, input logic [3:0] c, input logic op);
        logic [31:0] w;
        if (op) return d >> c;
        w = {d, d} >> c;
        return w[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(bus.rsp_data), 32'(e[15:0]));
                    check("sb_id", 32'(bus.rsp_id), 32'(e[16]));
                end
            end
            if (bus.req0_ready || bus.req1_ready)
                check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.req0_valid && bus.req0_ready)
                sb.push_back({1'b0, exp_shift(bus.req0_in, bus.req0_cnt, bus.req0_op)});
            if (bus.req1_valid && bus.req1_ready)
                sb.push_back({1'b1, exp_shift(bus.req1_in, bus.req1_cnt, bus.req1_op)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] c, input logic op);
        bus.req0_valid = v; bus.req0_in = d; bus.req0_cnt = c; bus.req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] c, input logic op);
        bus.req1_valid = v; bus.req1_in = d; bus.req1_cnt = c; bus.req1_op = op;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        set0(1'b1, 16'h8001, 4'd1, 1'b0);
        set1(1'b0, 16'h0, 4'd0, 1'b0);

        // Reset state, readies gated while reset is high
        mid();
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0000);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);

        // Single request
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        mid();
        check("single_req0_ready", 32'(bus.req0_ready), 32'd1);
        check("single_req1_ready", 32'(bus.req1_ready), 32'd0);
        check("single_sh_in", 32'(bus.sh_in), 32'h8001);
        check("single_sh_cnt", 32'(bus.sh_cnt), 32'd1);
        check("single_sh_op", 32'(bus.sh_op), 32'd0);
        check("single_lat_valid0", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        mid();
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_data", 32'(bus.rsp_data), 32'hC000);
        check("single_rsp_id", 32'(bus.rsp_id), 32'd0);
        tick();
        mid();
        check("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("drain_hold_data", 32'(bus.rsp_data), 32'hC000);
        check("drain_busy", 32'(bus.busy), 32'd0);
        check("idle_sh_in", 32'(bus.sh_in), 32'h0000);

        // Tie and alternation from reset
        do_reset();
        set0(1'b1, 16'h00F0, 4'd4, 1'b1);
        set1(1'b1, 16'hFFFF, 4'd15, 1'b1);
        for (int k = 0; k < 4; k++) begin
            mid();
            check("tie_req0_ready", 32'(bus.req0_ready), 32'((k % 2) == 0));
            check("tie_req1_ready", 32'(bus.req1_ready), 32'((k % 2) == 1));
            if (k > 0) begin
                check("tie_rsp_data", 32'(bus.rsp_data), (k % 2 == 1) ? 32'h000F : 32'h0001);
                check("tie_rsp_id", 32'(bus.rsp_id), (k % 2 == 1) ? 32'd0 : 32'd1);
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        mid();
        check("tie_last_data", 32'(bus.rsp_data), 32'h0001);
        tick();
        mid();
        check("tie_drained", 32'(bus.rsp_valid), 32'd0);

        // Backpressure
        tick();
        set1(1'b1, 16'h1234, 4'd0, 1'b1);
        bus.rsp_ready = 1'b0;
        mid();
        check("bp_fill_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        set0(1'b1, 16'h0F00, 4'd8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'h1234);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        mid();
        check("bp_release_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        mid();
        check("bp_replace_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_replace_data", 32'(bus.rsp_data), 32'h000F);
        check("bp_replace_id", 32'(bus.rsp_id), 32'd0);
        tick();
        mid();
        check("bp_drained", 32'(bus.rsp_valid), 32'd0);

        // Pass-through and rotate wrap
        tick();
        set1(1'b1, 16'hA5A5, 4'd0, 1'b0);
        mid();
        check("pass_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(1'b1, 16'h0001, 4'd15, 1'b0);
        mid();
        check("pass_data", 32'(bus.rsp_data), 32'hA5A5);
        check("pass_id", 32'(bus.rsp_id), 32'd1);
        check("wrap_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        mid();
        check("wrap_data", 32'(bus.rsp_data), 32'h0002);

        // Reset mid-operation with req0 as last winner
        tick();
        set0(1'b1, 16'h1000, 4'd4, 1'b1);
        bus.rsp_ready = 1'b0;
        mid();
        check("mid_pre_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        set1(1'b1, 16'hFFFF, 4'd15, 1'b1);
        mid();
        check("mid_full_ready0", 32'(bus.req0_ready), 32'd0);
        check("mid_full_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rsp_data", 32'(bus.rsp_data), 32'h0000);
        check("async_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("async_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("async_req1_ready", 32'(bus.req1_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        mid();
        check("post_rst_ready0", 32'(bus.req0_ready), 32'd1);
        check("post_rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        mid();
        check("post_rst_data0", 32'(bus.rsp_data), 32'h0100);
        check("post_rst_id0", 32'(bus.rsp_id), 32'd0);
        check("post_rst_ready1b", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        mid();
        check("post_rst_data1", 32'(bus.rsp_data), 32'h0001);
        check("post_rst_id1", 32'(bus.rsp_id), 32'd1);
        tick();
        mid();
        check("end_idle", 32'(bus.rsp_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Round-robin arbiter sharing one 16-bit barrel shifter between two requesters (execute stage and the address/memory-alignment unit).
- Drives the shifter's data, count and op inputs combinationally from the granted requester.
- Registers the shifter result into a one-entry output slot with valid/ready backpressure.
- Sustains one shift per cycle when the consumer is ready.

Parameters:
- N, 16, data width of shifter and all data ports.
- C, 4, shift-count width; log2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a shift pending.
- req0_in  input  N  requester 0 operand.
- req0_cnt  input  C  requester 0 shift amount.
- req0_op  input  1  requester 0 op: 1 = logical right shift (zero fill), 0 = rotate right.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid, req1_in, req1_cnt, req1_op, req1_ready  same as requester 0, for requester 1.
- sh_in  output  N  to shifter In.
- sh_cnt  output  C  to shifter Cnt.
- sh_op  output  1  to shifter Op.
- sh_out  input  N  from shifter Out (combinational).
- rsp_valid  output  1  result slot full.
- rsp_data  output  N  registered shift result.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_ready  input  1  consumer takes result this cycle.
- busy  output  1  rsp_valid high or any reqX_valid high.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - last_grant=1, so requester 0 wins the first tie.
  - reqX_ready=0 while rst is high.
- Slot state:
  - slot_free = !rsp_valid || rsp_ready. Two effective states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- Grant (combinational, same cycle):
  - Requires slot_free and at least one valid.
  - Only one requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - No grant: sh_in/sh_cnt/sh_op driven 0.
- Handshake:
  - reqX_ready=1 only for the granted requester; a transfer occurs when valid && ready.
  - Requester holds in/cnt/op stable until ready.
  - reqX_ready must not depend on the other requester's ready.
- Capture (rising edge after a grant):
  - rsp_data<=sh_out, rsp_id<=grant index, rsp_valid<=1, last_grant<=grant index.
  - Latency: one cycle from acceptance to rsp_valid.
- Drain:
  - FULL && rsp_ready && no grant: rsp_valid<=0 next edge; rsp_data and rsp_id hold their last values.
  - FULL && rsp_ready && grant: slot overwritten with the new result; rsp_valid stays 1 (back-to-back, one per cycle).
- Backpressure:
  - FULL && !rsp_ready: both readies 0; rsp_data, rsp_id and rsp_valid held stable; last_grant unchanged.
- last_grant updates only on an actual grant, never on idle cycles.
- Shifter math is not redone here. Required result equals the shifter's: op=1 gives in>>cnt zero-filled; op=0 gives rotate-right by cnt. cnt=0 passes the operand through.
- Reset mid-operation: a pending result is discarded with no response. An in-flight grant is lost; the requester keeps valid high and is re-arbitrated after reset deassertion.
- No combinational path from rsp_ready to rsp_data; rsp_ready reaches reqX_ready only via slot_free.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → rsp_valid=0, rsp_data=0x0000, rsp_id=0, both readies 0 immediately.
- Single request: req0 in=0x8001, cnt=1, op=0, rsp_ready=1 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_data=0xC000, rsp_id=0.
- Tie and alternation:
  - After reset, both valid every cycle: req0 (0x00F0, cnt 4, op 1) and req1 (0xFFFF, cnt 15, op 1); rsp_ready=1.
  - Required grants: req0, req1, req0, ...
  - Required responses: 0x000F/id0, then 0x0001/id1, then 0x000F/id0 on consecutive cycles.
- Backpressure: slot FULL with 0x1234/id1, rsp_ready=0 for 3 cycles, req0 valid → readies 0, rsp_data stays 0x1234. Raise rsp_ready → req0 granted that cycle and its result replaces the slot next cycle.
- Pass-through and rotate wrap: req1 in=0xA5A5, cnt=0, op=0 → 0xA5A5/id1. Then in=0x0001, cnt=15, op=0 → 0x0002.
- Reset mid-operation: rst pulse while rsp_valid=1 and req0 valid → slot cleared, no response for the discarded result. After release, req0 granted first even if req1 was last granted before reset.
